// File: rtl/lsu_bus_adapter_if.sv
// Data-bus side of the load/store adapter: valid/ready request channel plus
// a read-data return channel driven by the memory side.
interface lsu_bus_adapter_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output valid, we, addr, be, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, be, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/lsu_bus_adapter.sv
// Load/store unit bridging the execute stage to a wait-stated data bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module lsu_bus_adapter #(
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [2:0]         req_func3,
  output logic               stall,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               misalign,
  output logic               bus_err,
  lsu_bus_adapter_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] ERR  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          we_reg;
  logic [1:0]    lsb_reg;
  logic [2:0]    func3_reg;
  logic          err_pend_reg;
  logic          mis_pend_reg;

  logic          rsp_valid_reg;
  logic [31:0]   rsp_rdata_reg;
  logic          misalign_reg;
  logic          bus_err_reg;
  logic          bus_valid_reg;
  logic          bus_we_reg;
  logic [31:0]   bus_addr_reg;
  logic [3:0]    bus_be_reg;
  logic [31:0]   bus_wdata_reg;

  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic          illegal_c;
  logic          mis_c;
  logic [31:0]   addr_c;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   shifted_c;
  logic [31:0]   ext_c;
  logic          timeout_c;

  // Request decode works straight off the core inputs, which are only
  // consumed in IDLE.
  always_comb begin
    is_byte   = (req_func3[1:0] == 2'b00);
    is_half   = (req_func3[1:0] == 2'b01);
    is_word   = (req_func3 == 3'b010);
    illegal_c = (req_func3 == 3'b011) || (req_func3 == 3'b110) || (req_func3 == 3'b111);
    addr_c    = req_addr;
    mis_c     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_c     = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
    if (is_half) addr_c[0]   = 1'b0;
    if (is_word) addr_c[1:0] = 2'b00;
`endif
    be_c = 4'b0000;
    if (is_byte)      be_c = 4'b0001 << addr_c[1:0];
    else if (is_half) be_c = 4'b0011 << {addr_c[1], 1'b0};
    else if (is_word) be_c = 4'b1111;
  end

  // Each byte lane picks its source byte so the addressed lane always
  // carries the low bits of the store data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_c[8*gi +: 8] = is_byte ? req_wdata[7:0] :
                                  is_half ? req_wdata[8*(gi%2) +: 8] :
                                            req_wdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    shifted_c = bus.rdata;
    if (func3_reg[1:0] == 2'b00)
      shifted_c = bus.rdata >> {lsb_reg, 3'b000};
    else if (func3_reg[1:0] == 2'b01)
      shifted_c = bus.rdata >> {lsb_reg[1], 4'b0000};
    case (func3_reg)
      3'b000:  ext_c = {{24{shifted_c[7]}},  shifted_c[7:0]};
      3'b001:  ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b100:  ext_c = {24'h0, shifted_c[7:0]};
      3'b101:  ext_c = {16'h0, shifted_c[15:0]};
      default: ext_c = shifted_c;
    endcase
  end

  assign timeout_c = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      lsb_reg       <= 2'b00;
      func3_reg     <= 3'b000;
      err_pend_reg  <= 1'b0;
      mis_pend_reg  <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      misalign_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
      bus_valid_reg <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= 32'h0;
      bus_be_reg    <= 4'h0;
      bus_wdata_reg <= 32'h0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            lsb_reg   <= addr_c[1:0];
            func3_reg <= req_func3;
            cnt_reg   <= '0;
            if (illegal_c || mis_c) begin
              state_reg    <= ERR;
              err_pend_reg <= illegal_c;
              mis_pend_reg <= mis_c;
            end else begin
              state_reg     <= REQ;
              bus_valid_reg <= 1'b1;
              bus_we_reg    <= req_we;
              bus_addr_reg  <= {addr_c[31:2], 2'b00};
              bus_be_reg    <= be_c;
              bus_wdata_reg <= wdata_c;
            end
          end
        end
        REQ: begin
          cnt_reg <= cnt_reg + 1'b1;
          // An accepted store is a completion; an accepted load is not yet.
          if (bus.ready && we_reg) begin
            bus_valid_reg <= 1'b0;
            state_reg     <= DONE;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= 32'h0;
            bus_err_reg   <= 1'b0;
          end else if (timeout_c) begin
            bus_valid_reg <= 1'b0;
            state_reg     <= DONE;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= 32'h0;
            bus_err_reg   <= 1'b1;
          end else if (bus.ready) begin
            bus_valid_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (bus.rvalid) begin
            state_reg     <= DONE;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= ext_c;
            bus_err_reg   <= 1'b0;
          end else if (timeout_c) begin
            state_reg     <= DONE;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= 32'h0;
            bus_err_reg   <= 1'b1;
          end
        end
        ERR: begin
          state_reg     <= DONE;
          rsp_valid_reg <= 1'b1;
          rsp_rdata_reg <= 32'h0;
          bus_err_reg   <= err_pend_reg;
          misalign_reg  <= mis_pend_reg;
        end
        DONE: begin
          state_reg     <= IDLE;
          rsp_rdata_reg <= 32'h0;
          bus_err_reg   <= 1'b0;
          misalign_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stall is the only combinational output; gating with rst_n releases the
  // core immediately when an access is aborted by reset.
  assign stall = rst_n && ((state_reg == IDLE && req_valid) ||
                           state_reg == REQ || state_reg == WAIT || state_reg == ERR);

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign misalign  = misalign_reg;
  assign bus_err   = bus_err_reg;
  assign bus.valid = bus_valid_reg;
  assign bus.we    = bus_we_reg;
  assign bus.addr  = bus_addr_reg;
  assign bus.be    = bus_be_reg;
  assign bus.wdata = bus_wdata_reg;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed vector bench for lsu_bus_adapter with a small wait-state bus responder.
module tb_lsu_bus_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic        stall, rsp_valid, misalign, bus_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  lsu_bus_adapter_if bus_if ();

  lsu_bus_adapter #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_func3 (req_func3),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          ready_wait;   // bus_valid cycles before ready
    int          rv_delay;     // cycles after acceptance cycle+1 until rvalid, -1 never
    logic [31:0] rdata;
    bit          exp_bus;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_mis;
    int          exp_lat;      // cycle of rsp_valid, request presented in cycle 0
  } vec_t;

  vec_t vecs[17];
  vec_t chain_st, chain_ld;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int acc_c, rw_cnt, stall_cnt, lat;
    bit saw, acc, done;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    acc_c = 0; rw_cnt = 0; stall_cnt = 0; lat = -1;
    saw = 0; acc = 0; done = 0;
    cap_addr = 0; cap_wdata = 0; cap_be = 0; cap_we = 0;
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_func3 = v.f3;
    req_valid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (bus_if.valid) begin
        if (!saw) begin
          cap_addr = bus_if.addr; cap_be = bus_if.be; cap_wdata = bus_if.wdata; cap_we = bus_if.we;
        end
        saw = 1;
        bus_if.ready = (rw_cnt == v.ready_wait);
        if (bus_if.ready) begin
          acc = 1; acc_c = c;
          cap_addr = bus_if.addr; cap_be = bus_if.be; cap_wdata = bus_if.wdata; cap_we = bus_if.we;
        end
        rw_cnt++;
      end else begin
        bus_if.ready = 1'b0;
      end
      bus_if.rvalid = acc && (c > acc_c) && (v.rv_delay >= 0) && (c == acc_c + 1 + v.rv_delay);
      bus_if.rdata  = bus_if.rvalid ? v.rdata : 32'hDEADBEEF;
      #1;
      if (stall) stall_cnt++;
      if (rsp_valid) begin
        lat = c; done = 1;
      end else begin
        @(negedge clk);
      end
    end
    bus_if.ready = 1'b0; bus_if.rvalid = 1'b0;
    chk("rsp_seen", idx, {31'h0, done}, 32'h1);
    chk("latency", idx, lat, v.exp_lat);
    chk("stall_cycles", idx, stall_cnt, v.exp_lat);
    chk("rsp_rdata", idx, rsp_rdata, v.exp_rdata);
    chk("bus_err", idx, {31'h0, bus_err}, {31'h0, v.exp_err});
    chk("misalign", idx, {31'h0, misalign}, {31'h0, v.exp_mis});
    chk("bus_seen", idx, {31'h0, saw}, {31'h0, v.exp_bus});
    if (v.exp_bus) begin
      chk("bus_addr", idx, cap_addr, v.exp_addr);
      chk("bus_be", idx, {28'h0, cap_be}, {28'h0, v.exp_be});
      chk("bus_wdata", idx, cap_wdata, v.exp_wdata);
      chk("bus_we", idx, {31'h0, cap_we}, {31'h0, v.we});
    end
  endtask

  initial begin
    //          we   addr          wdata         f3      rw  rv  rdata        bus be     exp_addr      exp_wdata     exp_rdata     err  mis  lat
    vecs[0]  = '{1'b1, 32'h00001003, 32'hAABBCC5A, 3'b000, 0,  -1, 32'h0,        1, 4'h8, 32'h00001000, 32'h5A5A5A5A, 32'h0,        1'b0, 1'b0, 2};
    vecs[1]  = '{1'b0, 32'h00002002, 32'h0,        3'b000, 0,  3,  32'h12F03456, 1, 4'h4, 32'h00002000, 32'h0,        32'hFFFFFFF0, 1'b0, 1'b0, 6};
    vecs[2]  = '{1'b0, 32'h00002002, 32'h0,        3'b100, 0,  3,  32'h12F03456, 1, 4'h4, 32'h00002000, 32'h0,        32'h000000F0, 1'b0, 1'b0, 6};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[3]  = '{1'b0, 32'h00003001, 32'h0,        3'b001, 0,  0,  32'h00008001, 0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 2};
`else
    vecs[3]  = '{1'b0, 32'h00003001, 32'h0,        3'b001, 0,  0,  32'h00008001, 1, 4'h3, 32'h00003000, 32'h0,        32'hFFFF8001, 1'b0, 1'b0, 3};
`endif
    vecs[4]  = '{1'b0, 32'h00004000, 32'h0,        3'b010, 0,  -1, 32'h0,        1, 4'hF, 32'h00004000, 32'h0,        32'h0,        1'b1, 1'b0, 9};
    vecs[5]  = '{1'b1, 32'h00006002, 32'h1234ABCD, 3'b001, 2,  -1, 32'h0,        1, 4'hC, 32'h00006000, 32'hABCDABCD, 32'h0,        1'b0, 1'b0, 4};
    vecs[6]  = '{1'b1, 32'h00007000, 32'hDEADBEEF, 3'b010, 0,  -1, 32'h0,        1, 4'hF, 32'h00007000, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 2};
    vecs[7]  = '{1'b0, 32'h00008002, 32'h0,        3'b101, 0,  1,  32'h9ABC0000, 1, 4'hC, 32'h00008000, 32'h0,        32'h00009ABC, 1'b0, 1'b0, 4};
    vecs[8]  = '{1'b0, 32'h00009000, 32'h0,        3'b010, 0,  0,  32'hCAFEF00D, 1, 4'hF, 32'h00009000, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 3};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[9]  = '{1'b0, 32'h0000A003, 32'h0,        3'b010, 0,  0,  32'h11223344, 0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 2};
`else
    vecs[9]  = '{1'b0, 32'h0000A003, 32'h0,        3'b010, 0,  0,  32'h11223344, 1, 4'hF, 32'h0000A000, 32'h0,        32'h11223344, 1'b0, 1'b0, 3};
`endif
    vecs[10] = '{1'b0, 32'h0000B002, 32'h0,        3'b001, 0,  0,  32'h80000000, 1, 4'hC, 32'h0000B000, 32'h0,        32'hFFFF8000, 1'b0, 1'b0, 3};
    vecs[11] = '{1'b0, 32'h0000C000, 32'h0,        3'b111, 0,  0,  32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 2};
    vecs[12] = '{1'b1, 32'h0000C004, 32'h55555555, 3'b110, 0,  -1, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 2};
    vecs[13] = '{1'b0, 32'h00000001, 32'h0,        3'b000, 0,  0,  32'h00007F00, 1, 4'h2, 32'h00000000, 32'h0,        32'h0000007F, 1'b0, 1'b0, 3};
    vecs[14] = '{1'b1, 32'h0000E000, 32'h01020304, 3'b010, 99, -1, 32'h0,        1, 4'hF, 32'h0000E000, 32'h01020304, 32'h0,        1'b1, 1'b0, 9};
    vecs[15] = '{1'b0, 32'h0000F000, 32'h0,        3'b010, 0,  6,  32'h5555AAAA, 1, 4'hF, 32'h0000F000, 32'h0,        32'h5555AAAA, 1'b0, 1'b0, 9};
    vecs[16] = '{1'b0, 32'h0000F004, 32'h0,        3'b010, 0,  7,  32'h5555AAAA, 1, 4'hF, 32'h0000F004, 32'h0,        32'h0,        1'b1, 1'b0, 9};
    chain_st = '{1'b1, 32'h00005000, 32'h0,        3'b011, 0,  -1, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 2};
    chain_ld = '{1'b0, 32'h0000C000, 32'h0,        3'b010, 0,  0,  32'h0BADF00D, 1, 4'hF, 32'h0000C000, 32'h0,        32'h0BADF00D, 1'b0, 1'b0, 3};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 0; req_wdata = 0; req_func3 = 0;
    bus_if.ready = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", -1, {31'h0, rsp_valid}, 32'h0);
    chk("reset_bus_valid", -1, {31'h0, bus_if.valid}, 32'h0);
    chk("reset_stall", -1, {31'h0, stall}, 32'h0);
    chk("reset_rdata", -1, rsp_rdata, 32'h0);
    chk("reset_flags", -1, {30'h0, bus_err, misalign}, 32'h0);
    chk("reset_bus_be", -1, {28'h0, bus_if.be}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // rvalid while idle must not produce a response
    bus_if.rvalid = 1'b1; bus_if.rdata = 32'h12345678;
    repeat (2) @(negedge clk);
    chk("idle_rvalid_rsp", -1, {31'h0, rsp_valid}, 32'h0);
    chk("idle_rvalid_stall", -1, {31'h0, stall}, 32'h0);
    bus_if.rvalid = 1'b0;

    // reset in the middle of a stalled REQ
    req_we = 1'b0; req_addr = 32'h0000D000; req_func3 = 3'b010; req_valid = 1'b1;
    @(negedge clk);
    chk("midreq_bus_valid", -1, {31'h0, bus_if.valid}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreq_rst_bus_valid", -1, {31'h0, bus_if.valid}, 32'h0);
    chk("midreq_rst_stall", -1, {31'h0, stall}, 32'h0);
    chk("midreq_rst_rsp_valid", -1, {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", -1, {31'h0, stall}, 32'h0);
    chk("post_rst_bus_valid", -1, {31'h0, bus_if.valid}, 32'h0);

    for (int i = 0; i < 17; i++) begin
      run_vec(vecs[i], i);
      $display("vec%0d we=%0b f3=%03b addr=%h -> rdata=%h err=%0b mis=%0b", i, vecs[i].we, vecs[i].f3,
               vecs[i].addr, rsp_rdata, bus_err, misalign);
      req_valid = 1'b0;
      @(negedge clk);
    end

    // illegal store, then a load presented during its DONE cycle
    run_vec(chain_st, 100);
    $display("vec100 illegal store -> err=%0b", bus_err);
    req_we = chain_ld.we; req_addr = chain_ld.addr; req_wdata = chain_ld.wdata; req_func3 = chain_ld.f3;
    #1;
    chk("done_ignores_req_stall", 101, {31'h0, stall}, 32'h0);
    @(negedge clk);
    run_vec(chain_ld, 101);
    $display("vec101 back-to-back LW -> rdata=%h err=%0b", rsp_rdata, bus_err);
    req_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
